// File: rtl/pattern_serial_tx.sv
// Serial pattern transmitter. Accepts a pattern word and a repeat count through
// a start/ready handshake, then shifts the pattern out MSB-first with idle gaps.
module pattern_serial_tx #(
  parameter int   WIDTH      = 4,
  parameter int   CNT_W      = 8,
  parameter int   GAP        = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_in,
  output logic             ready,
  output logic             out,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GC_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WIDTH - 1);
  localparam logic [GC_W-1:0] GAP_LAST = GC_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t           r_state,   w_state_nxt;
  logic [WIDTH-1:0] r_pat,     w_pat_nxt;
  logic [WIDTH-1:0] r_shift,   w_shift_nxt;
  logic [BC_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [GC_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic [CNT_W-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic             r_out,     w_out_nxt;
  logic             r_frame,   w_frame_nxt;
  logic             r_busy,    w_busy_nxt;
  logic             r_done,    w_done_nxt;

  // r_shift holds the bits still to come after the one currently on out.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    w_state_nxt   = r_state;
    w_pat_nxt     = r_pat;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_rep_cnt_nxt = r_rep_cnt;
    w_out_nxt     = IDLE_LEVEL;
    w_frame_nxt   = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pat_nxt     = pat_in;
          w_rep_cnt_nxt = rep_in;
          w_busy_nxt    = 1'b1;
          if (rep_in != '0) begin
            w_state_nxt   = S_SHIFT;
            w_out_nxt     = pat_in[WIDTH-1];
            w_frame_nxt   = 1'b1;
            w_shift_nxt   = pat_in << 1;
            w_bit_cnt_nxt = '0;
          end else begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end

      S_SHIFT: begin
        w_busy_nxt = 1'b1;
        if (r_bit_cnt == BIT_LAST) begin
          w_rep_cnt_nxt = r_rep_cnt - CNT_W'(1);
          if (r_rep_cnt > CNT_W'(1)) begin
            if (GAP > 0) begin
              w_state_nxt   = S_GAP;
              w_gap_cnt_nxt = '0;
            end else begin
              w_out_nxt     = r_pat[WIDTH-1];
              w_frame_nxt   = 1'b1;
              w_shift_nxt   = r_pat << 1;
              w_bit_cnt_nxt = '0;
            end
          end else begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_out_nxt     = r_shift[WIDTH-1];
          w_frame_nxt   = 1'b1;
          w_shift_nxt   = r_shift << 1;
          w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
        end
      end

      S_GAP: begin
        w_busy_nxt = 1'b1;
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt   = S_SHIFT;
          w_out_nxt     = r_pat[WIDTH-1];
          w_frame_nxt   = 1'b1;
          w_shift_nxt   = r_pat << 1;
          w_bit_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GC_W'(1);
        end
      end

      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state   <= S_IDLE;
      r_pat     <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_rep_cnt <= '0;
      r_out     <= IDLE_LEVEL;
      r_frame   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pat     <= w_pat_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
      r_out     <= w_out_nxt;
      r_frame   <= w_frame_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign ready = (r_state == S_IDLE);
  assign out   = r_out;
  assign frame = r_frame;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_pattern_serial_tx.sv
// Bench for pattern_serial_tx: two instances (GAP=2 and GAP=0) share stimulus and
// are checked every cycle against a per-cycle expectation queue built from the frame rules.
module tb_pattern_serial_tx;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] pat_in = '0;
  logic [CNT_W-1:0] rep_in = '0;
  logic ready_g2, out_g2, frame_g2, busy_g2, done_g2;
  logic ready_g0, out_g0, frame_g0, busy_g0, done_g0;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic chk_en   = 1'b0;

  typedef struct packed {logic o; logic f; logic b; logic d;} exp_t;
  exp_t q_g2[$];
  exp_t q_g0[$];

  always #5 clk = ~clk;

  pattern_serial_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(2), .IDLE_LEVEL(1'b0)) dut_g2 (
    .clk(clk), .reset(reset), .start(start), .pat_in(pat_in), .rep_in(rep_in),
    .ready(ready_g2), .out(out_g2), .frame(frame_g2), .busy(busy_g2), .done(done_g2)
  );

  pattern_serial_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(0), .IDLE_LEVEL(1'b0)) dut_g0 (
    .clk(clk), .reset(reset), .start(start), .pat_in(pat_in), .rep_in(rep_in),
    .ready(ready_g0), .out(out_g0), .frame(frame_g0), .busy(busy_g0), .done(done_g0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Whole transfer as a list of visible cycles: R patterns MSB-first, G idle cycles between, one done cycle.
  task automatic push_seq(input bit to_g0, input int g, input logic [WIDTH-1:0] p, input int r);
    exp_t seq[$];
    for (int k = 0; k < r; k++) begin
      for (int b = WIDTH - 1; b >= 0; b--) seq.push_back('{o: p[b], f: 1'b1, b: 1'b1, d: 1'b0});
      if (k < r - 1)
        for (int j = 0; j < g; j++) seq.push_back('{o: 1'b0, f: 1'b0, b: 1'b1, d: 1'b0});
    end
    seq.push_back('{o: 1'b0, f: 1'b0, b: 1'b1, d: 1'b1});
    foreach (seq[i]) begin
      if (to_g0) q_g0.push_back(seq[i]);
      else       q_g2.push_back(seq[i]);
    end
  endtask

  // Model: an empty queue means the transmitter is idle and would accept a start.
  always @(posedge clk) begin
    if (reset) begin
      q_g2.delete();
      q_g0.delete();
    end else begin
      if (q_g2.size() > 0) void'(q_g2.pop_front());
      else if (start) push_seq(1'b0, 2, pat_in, int'(rep_in));
      if (q_g0.size() > 0) void'(q_g0.pop_front());
      else if (start) push_seq(1'b1, 0, pat_in, int'(rep_in));
    end
  end

  always @(negedge clk) begin
    exp_t e2, e0;
    if (chk_en) begin
      e2 = (q_g2.size() > 0) ? q_g2[0] : '0;
      e0 = (q_g0.size() > 0) ? q_g0[0] : '0;
      check("g2.ready", ready_g2, q_g2.size() == 0);
      check("g2.out",   out_g2,   e2.o);
      check("g2.frame", frame_g2, e2.f);
      check("g2.busy",  busy_g2,  e2.b);
      check("g2.done",  done_g2,  e2.d);
      check("g0.ready", ready_g0, q_g0.size() == 0);
      check("g0.out",   out_g0,   e0.o);
      check("g0.frame", frame_g0, e0.f);
      check("g0.busy",  busy_g0,  e0.b);
      check("g0.done",  done_g0,  e0.d);
    end
  end

  task automatic send(input logic [WIDTH-1:0] p, input int r);
    @(negedge clk);
    start  = 1'b1;
    pat_in = p;
    rep_in = CNT_W'(r);
    @(negedge clk);
    start  = 1'b0;
    pat_in = WIDTH'($urandom);
    rep_in = CNT_W'($urandom);
  endtask

  // Records n visible cycles starting with the first cycle after accept (MSB = earliest).
  task automatic capture(input int n, input int poke_at,
                         output logic [31:0] o2, output logic [31:0] f2,
                         output logic [31:0] o0, output logic [31:0] f0,
                         output int d2, output int d0, output int hits);
    logic [3:0] det;
    o2 = '0; f2 = '0; o0 = '0; f0 = '0; d2 = 0; d0 = 0; hits = 0; det = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (i == poke_at) begin
        start = 1'b1; pat_in = '0; rep_in = CNT_W'(3);
      end else if (i == poke_at + 1) begin
        start = 1'b0;
      end
      o2 = {o2[30:0], out_g2};  f2 = {f2[30:0], frame_g2};
      o0 = {o0[30:0], out_g0};  f0 = {f0[30:0], frame_g0};
      if (done_g2 && d2 == 0) d2 = i + 1;
      if (done_g0 && d0 == 0) d0 = i + 1;
      det = {det[2:0], out_g2};
      if (det == 4'b1010) hits++;
    end
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(ready_g2 && ready_g0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle", ready_g2 && ready_g0, 1);
  endtask

  initial begin
    logic [31:0] o2, f2, o0, f0;
    int d2, d0, hits;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle.state", {ready_g2, out_g2, frame_g2, busy_g2, done_g2}, 5'b10000);
    end

    send(4'b1010, 1);
    capture(8, -1, o2, f2, o0, f0, d2, d0, hits);
    check("single.out",   o2[7:4], 4'b1010);
    check("single.frame", f2[7:0], 8'b11110000);
    check("single.done",  d2, 5);
    check("single.det",   hits, 1);
    check("single.g0",    o0[7:4], 4'b1010);

    send(4'b1010, 2);
    capture(12, -1, o2, f2, o0, f0, d2, d0, hits);
    check("rep2.out",   o2[11:2], 10'b1010001010);
    check("rep2.frame", f2[11:2], 10'b1111001111);
    check("rep2.done",  d2, 11);
    check("rep2.g0out", o0[11:4], 8'b10101010);
    check("rep2.g0done", d0, 9);

    send(4'b1101, 3);
    capture(14, -1, o2, f2, o0, f0, d2, d0, hits);
    check("b2b.out",   o0[13:2], 12'b110111011101);
    check("b2b.frame", f0[13:2], 12'hfff);
    check("b2b.done",  d0, 13);
    check("b2b.g2notdone", d2, 0);
    wait_idle(20);

    send(4'b1111, 0);
    capture(3, -1, o2, f2, o0, f0, d2, d0, hits);
    check("rep0.done",  d2, 1);
    check("rep0.frame", f2[2:0], 3'b000);
    check("rep0.g0done", d0, 1);
    check("rep0.out",   o0[2:0], 3'b000);

    send(4'b1010, 2);
    capture(12, 3, o2, f2, o0, f0, d2, d0, hits);
    check("ignore.out",  o2[11:2], 10'b1010001010);
    check("ignore.done", d2, 11);
    wait_idle(20);

    send(4'b1010, 5);
    capture(6, -1, o2, f2, o0, f0, d2, d0, hits);
    check("rstmid.g0bits", o0[5:0], 6'b101010);
    check("rstmid.g2bits", o2[5:0], 6'b101000);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid.g2", {out_g2, frame_g2, busy_g2, done_g2}, 4'b0000);
    check("rstmid.g0", {out_g0, frame_g0, busy_g0, done_g0}, 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    check("rstmid.ready", {ready_g2, ready_g0, done_g2, done_g0}, 4'b1100);
    send(4'b0110, 1);
    capture(5, -1, o2, f2, o0, f0, d2, d0, hits);
    check("rstmid.new", o2[4:1], 4'b0110);
    check("rstmid.newdone", d2, 5);

    send(4'b1001, 255);
    begin
      int c = 1;
      d2 = 0; d0 = 0;
      while ((d2 == 0 || d0 == 0) && c < 1600) begin
        if (done_g0 && d0 == 0) d0 = c;
        if (done_g2 && d2 == 0) d2 = c;
        if (d2 == 0 || d0 == 0) begin
          @(negedge clk);
          c++;
        end
      end
    end
    check("max.g0len", d0, 1021);
    check("max.g2len", d2, 1529);
    wait_idle(10);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 3) == 0);
      pat_in = WIDTH'($urandom);
      rep_in = CNT_W'($urandom_range(0, 3));
      reset  = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
